// File: rtl/paddle_motion_if.sv
// rtl/paddle_motion_if.sv - command and status bundle for paddle_motion
interface paddle_motion_if;
    logic       frame_tick;
    logic       move_up;
    logic       move_down;
    logic       recenter;
    logic [7:0] paddle_y;
    logic [2:0] speed;
    logic       moving;
    logic       at_top;
    logic       at_bottom;

    modport master (
        output frame_tick, move_up, move_down, recenter,
        input  paddle_y, speed, moving, at_top, at_bottom
    );

    modport slave (
        input  frame_tick, move_up, move_down, recenter,
        output paddle_y, speed, moving, at_top, at_bottom
    );
endinterface

// File: rtl/paddle_motion.sv
// rtl/paddle_motion.sv - frame-ticked paddle position FSM with speed ramping
module paddle_motion #(
    parameter int SCREEN_H    = 120,
    parameter int PADDLE_H    = 16,
    parameter int HOME_Y      = 52,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_TICKS = 4
) (
    input  logic            clk,
    input  logic            resetn,
    paddle_motion_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    localparam logic [8:0] BOTTOM_Y9  = 9'(SCREEN_H - PADDLE_H);
    localparam logic [7:0] BOTTOM_Y   = 8'(SCREEN_H - PADDLE_H);
    localparam logic [7:0] HOME_POS   = 8'(HOME_Y);
    localparam logic [2:0] SPEED_MAX  = 3'(MAX_SPEED);
    localparam logic [3:0] HOLD_LAST  = 4'(ACCEL_TICKS - 1);
    // The entry tick itself counts toward the first ramp period.
    localparam logic [3:0] HOLD_ENTRY = (ACCEL_TICKS == 1) ? 4'd0 : 4'd1;

    logic [1:0] state_q, state_nxt;
    logic [7:0] y_q, y_nxt;
    logic [2:0] speed_q, speed_nxt;
    logic [3:0] hold_q, hold_nxt;
    logic [2:0] step;
    logic [8:0] y9, step9, sum9;
    logic       up_only, down_only;

    always_comb begin
        up_only   = bus.move_up & ~bus.move_down;
        down_only = bus.move_down & ~bus.move_up;
        state_nxt = ST_IDLE;
        speed_nxt = 3'd0;
        hold_nxt  = 4'd0;
        step      = 3'd0;
        y_nxt     = y_q;

        if (up_only) begin
            state_nxt = ST_UP;
        end else if (down_only) begin
            state_nxt = ST_DOWN;
        end

        if (state_nxt != ST_IDLE) begin
            if (state_nxt != state_q) begin
                speed_nxt = 3'd1;
                hold_nxt  = HOLD_ENTRY;
                step      = 3'd1;
            end else begin
                step      = speed_q;
                speed_nxt = speed_q;
                if (hold_q == HOLD_LAST) begin
                    hold_nxt = 4'd0;
                    if (speed_q < SPEED_MAX) begin
                        speed_nxt = speed_q + 3'd1;
                    end
                end else begin
                    hold_nxt = hold_q + 4'd1;
                end
            end
        end

        y9    = {1'b0, y_q};
        step9 = {6'd0, step};
        sum9  = y9 + step9;
        // Clamp in 9 bits so neither edge can wrap around.
        if (state_nxt == ST_UP) begin
            y_nxt = (y9 < step9) ? 8'd0 : 8'(y9 - step9);
        end else if (state_nxt == ST_DOWN) begin
            y_nxt = (sum9 > BOTTOM_Y9) ? BOTTOM_Y : sum9[7:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            y_q     <= HOME_POS;
            speed_q <= 3'd0;
            hold_q  <= 4'd0;
        end else if (bus.recenter) begin
            state_q <= ST_IDLE;
            y_q     <= HOME_POS;
            speed_q <= 3'd0;
            hold_q  <= 4'd0;
        end else if (bus.frame_tick) begin
            state_q <= state_nxt;
            y_q     <= y_nxt;
            speed_q <= speed_nxt;
            hold_q  <= hold_nxt;
        end
    end

    assign bus.paddle_y  = y_q;
    assign bus.speed     = speed_q;
    assign bus.moving    = (state_q != ST_IDLE);
    assign bus.at_top    = (y_q == 8'd0);
    assign bus.at_bottom = (y_q == BOTTOM_Y);
endmodule

// File: tb/tb_paddle_motion.sv
// tb/tb_paddle_motion.sv - directed vector bench for paddle_motion
module tb_paddle_motion;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    paddle_motion_if bus ();

    paddle_motion dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic tick;
        logic up;
        logic down;
        logic rc;
        int   y;
        int   spd;
        int   mov;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic t, input logic u, input logic d, input logic r,
                                input int y, input int s, input int m);
        vec_t v;
        v.tick = t; v.up = u; v.down = d; v.rc = r;
        v.y = y; v.spd = s; v.mov = m;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int y, input int s, input int m);
        check({tag, " paddle_y"}, int'(bus.paddle_y), y);
        check({tag, " speed"}, int'(bus.speed), s);
        check({tag, " moving"}, int'(bus.moving), m);
        check({tag, " at_top"}, int'(bus.at_top), (y == 0) ? 1 : 0);
        check({tag, " at_bottom"}, int'(bus.at_bottom), (y == 104) ? 1 : 0);
    endtask

    task automatic drive(input logic t, input logic u, input logic d, input logic r);
        bus.frame_tick = t;
        bus.move_up    = u;
        bus.move_down  = d;
        bus.recenter   = r;
    endtask

    initial begin
        drive(0, 0, 0, 0);

        // Twelve held DOWN ticks from reset
        add(1,0,1,0, 53,1,1); add(1,0,1,0, 54,1,1); add(1,0,1,0, 55,1,1); add(1,0,1,0, 56,2,1);
        add(1,0,1,0, 58,2,1); add(1,0,1,0, 60,2,1); add(1,0,1,0, 62,2,1); add(1,0,1,0, 64,3,1);
        add(1,0,1,0, 67,3,1); add(1,0,1,0, 70,3,1); add(1,0,1,0, 73,3,1); add(1,0,1,0, 76,4,1);
        // Reversal at full speed steps exactly 1
        add(1,1,0,0, 75,1,1);
        // Ramp DOWN to speed 3, then both buttons
        add(1,0,1,0, 76,1,1); add(1,0,1,0, 77,1,1); add(1,0,1,0, 78,1,1); add(1,0,1,0, 79,2,1);
        add(1,0,1,0, 81,2,1); add(1,0,1,0, 83,2,1); add(1,0,1,0, 85,2,1); add(1,0,1,0, 87,3,1);
        add(1,1,1,0, 87,0,0); add(1,0,0,0, 87,0,0);
        // Commands between ticks are ignored
        add(0,1,0,0, 87,0,0); add(0,0,1,0, 87,0,0); add(0,1,1,0, 87,0,0);
        add(1,0,1,0, 88,1,1); add(0,1,0,0, 88,1,1); add(0,0,0,0, 88,1,1);
        // Into the bottom clamp, ramping continues while pinned
        add(1,0,1,0, 89,1,1); add(1,0,1,0, 90,1,1); add(1,0,1,0, 91,2,1); add(1,0,1,0, 93,2,1);
        add(1,0,1,0, 95,2,1); add(1,0,1,0, 97,2,1); add(1,0,1,0, 99,3,1); add(1,0,1,0, 102,3,1);
        add(1,0,1,0, 104,3,1); add(1,0,1,0, 104,3,1); add(1,0,1,0, 104,4,1); add(1,0,1,0, 104,4,1);
        // Recenter off-tick and on-tick, both overriding commands
        add(0,0,1,1, 52,0,0); add(1,0,1,1, 52,0,0);
        // Set up paddle_y=2 at speed 4 going UP, then hit the top
        add(1,0,1,0, 53,1,1); add(1,0,1,0, 54,1,1);
        add(1,1,0,0, 53,1,1); add(1,1,0,0, 52,1,1); add(1,1,0,0, 51,1,1); add(1,1,0,0, 50,2,1);
        add(1,1,0,0, 48,2,1); add(1,1,0,0, 46,2,1); add(1,1,0,0, 44,2,1); add(1,1,0,0, 42,3,1);
        add(1,1,0,0, 39,3,1); add(1,1,0,0, 36,3,1); add(1,1,0,0, 33,3,1); add(1,1,0,0, 30,4,1);
        add(1,1,0,0, 26,4,1); add(1,1,0,0, 22,4,1); add(1,1,0,0, 18,4,1); add(1,1,0,0, 14,4,1);
        add(1,1,0,0, 10,4,1); add(1,1,0,0, 6,4,1);  add(1,1,0,0, 2,4,1);  add(1,1,0,0, 0,4,1);
        add(1,1,0,0, 0,4,1);  add(1,1,0,0, 0,4,1);

        // Reset state, including a clocked tick while held in reset
        @(negedge clk);
        drive(1, 0, 1, 0);
        @(posedge clk); #1;
        check_outputs("reset", 52, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].tick, vecs[i].up, vecs[i].down, vecs[i].rc);
            @(posedge clk); #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].y, vecs[i].spd, vecs[i].mov);
        end

        // Asynchronous reset mid-motion, then first tick evaluated from IDLE
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1, 0, 1, 0);
            @(posedge clk); #1;
        end
        check_outputs("pre_reset", 3, 1, 1);
        #2;
        resetn = 1'b0;
        #1;
        check_outputs("async_reset", 52, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        drive(1, 0, 1, 0);
        @(posedge clk); #1;
        check_outputs("after_reset", 53, 1, 1);

        @(negedge clk);
        drive(0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
